// File: rtl/enc_pkg.sv
// Shared defaults and FSM state encoding for the sequential 8-to-3 priority encoder.
// Optional round-robin selection is enabled by defining ENC_ROUND_ROBIN_EN.
package enc_pkg;

  localparam int N_REQ_DEFAULT  = 8;
  localparam int CODE_W_DEFAULT = $clog2(N_REQ_DEFAULT);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_sel.sv
// Combinational request selector: scans pending bits from a start pointer and reports the winner.
// ENC_ROUND_ROBIN_EN selects an ascending wrap search; otherwise a descending search from start-1.
module prio_sel
  import enc_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int CODE_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]  pending,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] index,
  output logic              any
);

  logic [CODE_W-1:0] pos;

  // Iterate from the far end so the candidate closest to the search origin is written last and wins.
  always_comb begin
    index = '0;
    pos   = '0;
    any   = |pending;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef ENC_ROUND_ROBIN_EN
      pos = start + CODE_W'(k);
`else
      pos = start - CODE_W'(k) - CODE_W'(1);
`endif
      if (pending[pos]) index = pos;
    end
  end

endmodule

// File: rtl/enc_8_3_irq.sv
// Sequential priority encoder: sticky pending capture, valid/ready code presentation.
// Define ENC_ROUND_ROBIN_EN for rotating selection; default is highest-index priority.
module enc_8_3_irq
  import enc_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEFAULT,
  parameter int CODE_W = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] y,
  output logic              valid,
  input  logic              ready,
  output logic [N_REQ-1:0]  pending
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t            state;
  logic              handshake;
  logic [N_REQ-1:0]  clr;
  logic [CODE_W-1:0] start;
  logic [CODE_W-1:0] sel_index;
  logic              sel_any;

`ifdef ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] rr_ptr;
  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  assign handshake = valid & ready;
  assign clr       = handshake ? (ONE << y) : '0;

  prio_sel #(
    .N_REQ (N_REQ),
    .CODE_W(CODE_W)
  ) u_prio_sel (
    .pending(pending),
    .start  (start),
    .index  (sel_index),
    .any    (sel_any)
  );

  // A new request in the same cycle as its own clear stays set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | (en ? req : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      y     <= '0;
      valid <= 1'b0;
`ifdef ENC_ROUND_ROBIN_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            y     <= sel_index;
            valid <= 1'b1;
            state <= PRESENT;
          end
        end
        PRESENT: begin
          if (ready) begin
            valid <= 1'b0;
            state <= IDLE;
`ifdef ENC_ROUND_ROBIN_EN
            rr_ptr <= y + CODE_W'(1);
`endif
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_8_3_irq.sv
// Self-checking bench for enc_8_3_irq: directed scenarios plus random traffic against a behavioural model.
// Honours ENC_ROUND_ROBIN_EN in the model when the design is built with it.
module tb_enc_8_3_irq;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [2:0] y;
  logic       valid;
  logic       ready;
  logic [7:0] pending;

  int checks;
  int failures;

  // Reference state: set of pending sources, code currently offered, rotation origin.
  bit [7:0] m_pending;
  bit       m_valid;
  int       m_y;
  int       m_rr;

  enc_8_3_irq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .req    (req),
    .y      (y),
    .valid  (valid),
    .ready  (ready),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pick(input bit [7:0] p, input int rr);
    int idx;
    idx = 0;
`ifdef ENC_ROUND_ROBIN_EN
    for (int k = 7; k >= 0; k--) if (p[(rr + k) % 8]) idx = (rr + k) % 8;
`else
    for (int i = 0; i < 8; i++) if (p[i]) idx = i;
`endif
    return idx;
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = '0;
    m_valid   = 1'b0;
    m_y       = 0;
    m_rr      = 0;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then compare just after the edge.
  task automatic step(input logic [7:0] r, input logic e, input logic rd);
    bit [7:0] clr;
    req   = r;
    en    = e;
    ready = rd;
    @(posedge clk);
    clr = (m_valid && rd) ? (8'd1 << m_y) : 8'd0;
    if (!m_valid) begin
      if (m_pending != 0) begin
        m_y     = pick(m_pending, m_rr);
        m_valid = 1'b1;
      end
    end else if (rd) begin
      m_valid = 1'b0;
      m_rr    = (m_y + 1) % 8;
    end
    m_pending = (m_pending & ~clr) | (e ? r : 8'd0);
    #1;
    check("pending", int'(pending), int'(m_pending));
    check("valid", int'(valid), int'(m_valid));
    check("y", int'(y), m_y);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req      = '0;
    ready    = 1'b0;
    model_reset();
    #12;
    check("reset_pending", int'(pending), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_y", int'(y), 0);
    rst_n = 1'b1;

    // Single request: captured, offered on the following edge, then retired.
    step(8'b0000_0100, 1'b1, 1'b1);
    check("t1_pending_captured", int'(pending), 4);
    check("t1_not_yet_valid", int'(valid), 0);
    step(8'h00, 1'b1, 1'b1);
    check("t1_valid", int'(valid), 1);
    check("t1_code", int'(y), 2);
    step(8'h00, 1'b1, 1'b1);
    check("t1_retired_valid", int'(valid), 0);
    check("t1_retired_pending", int'(pending), 0);

    // Two sources in one pulse.
    step(8'b1000_0001, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 1'b1);

    // Back-pressure: the offered code must hold while a higher source arrives.
    step(8'b0010_0000, 1'b1, 1'b0);
    step(8'h00, 1'b1, 1'b0);
    step(8'b1000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h00, 1'b1, 1'b1);

    // A level held across its own handshake is re-captured.
    for (int i = 0; i < 6; i++) step(8'b0000_1000, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b1);

    // Capture gating blocks only new requests.
    for (int i = 0; i < 3; i++) step(8'hFF, 1'b0, 1'b1);
    step(8'h01, 1'b1, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b1);
    step(8'hFF, 1'b0, 1'b1);

    // All sources at once.
    step(8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 18; i++) step(8'h00, 1'b1, 1'b1);

    // Random traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset_valid", int'(valid), 0);
        check("async_reset_pending", int'(pending), 0);
        rst_n = 1'b1;
      end
      step(8'($urandom) & 8'($urandom) & 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
